ddr_port_arbiter: RTL
=====================

DDR_PORT_ARBITER -- requirements
Module: ddr_port_arbiter

Interface
REQ-001 The module SHALL have parameter ADDR_WIDTH, default 32 (CONF_DDR_ADDR_WIDTH), DDR byte-address width.
REQ-002 The module SHALL have parameter LEN_WIDTH, default 23, transfer-length field width in bytes.
REQ-003 The module SHALL have parameters FM_LEN, WT_LEN and SAVE_LEN, each default 23'd10240, fixed byte lengths for feature-map load, weight load and result save.
REQ-004 Ports (clock and reset first):
- clk  in  1  sole clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  3  level requests; bit0 FM load, bit1 WT load, bit2 SAVE.
- fm_addr, wt_addr, save_addr  in  ADDR_WIDTH each  start address per requester.
- grant  out  3  one-hot owner of the DDR port.
- done  out  3  one-cycle completion pulse to the owning requester.
- cmd_valid  out  1  command valid to the DDR engine.
- cmd_ready  in  1  DDR engine accepts the command.
- cmd_addr  out  ADDR_WIDTH  command start address.
- cmd_len  out  LEN_WIDTH  command byte length.
- cmd_write  out  1  1 = write (SAVE), 0 = read.
- xfer_done  in  1  single-cycle pulse: DDR engine finished the accepted command.
- busy  out  1  high in every state except IDLE.
- err  out  1  sticky protocol-error flag.

Function
REQ-005 The FSM SHALL have four states: IDLE, ISSUE, BUSY, DONE.
REQ-006 In IDLE with req != 0, the arbiter SHALL select one requester, register grant, cmd_addr, cmd_len and cmd_write, and enter ISSUE on the next edge; with req == 0 it SHALL stay in IDLE.
REQ-007 Selection SHALL be round-robin: search order starts at (last_grant+1) mod 3 and wraps; last_grant resets to 2, so the post-reset priority is FM, WT, SAVE.
REQ-008 cmd_len SHALL be FM_LEN, WT_LEN or SAVE_LEN for the selected requester; cmd_write SHALL be 1 only for SAVE.
REQ-009 The address SHALL be captured at grant time; changes on *_addr after that SHALL NOT affect cmd_addr until the next grant.
REQ-010 In ISSUE, cmd_valid SHALL be 1, and cmd_addr, cmd_len and cmd_write SHALL stay stable until cmd_valid && cmd_ready; on that edge the FSM SHALL enter BUSY and cmd_valid SHALL drop to 0.
REQ-011 In BUSY, xfer_done = 1 SHALL move the FSM to DONE; otherwise it SHALL wait with no timeout.
REQ-012 In DONE (exactly one cycle), done SHALL equal the previous grant, grant SHALL be 0, last_grant SHALL be updated, and the FSM SHALL return to IDLE; no arbitration SHALL occur in DONE.
REQ-013 A requester SHALL deassert req in the cycle after its done pulse. In IDLE the arbiter SHALL treat the requester that just completed as lowest priority, which follows from round-robin.
REQ-014 grant SHALL be nonzero and one-hot in ISSUE and BUSY, and zero in IDLE and DONE.
REQ-015 A requester dropping req after grant SHALL NOT abort the transfer; the FSM SHALL complete through DONE.
REQ-016 xfer_done asserted in IDLE, ISSUE or DONE SHALL be ignored for state purposes and SHALL set err; err SHALL clear only on rst.
REQ-017 busy SHALL be a registered function of state, asserted in ISSUE, BUSY and DONE.

Reset
REQ-018 While rst = 1 on a clock edge, the outputs SHALL be: state = IDLE, grant = 0, done = 0, cmd_valid = 0, cmd_addr = 0, cmd_len = 0, cmd_write = 0, busy = 0, err = 0, last_grant = 2.
REQ-019 A reset asserted mid-transfer (ISSUE or BUSY) SHALL abandon the transfer without a done pulse; the arbiter SHALL restart from IDLE after rst falls.

Verification
REQ-020 Single request: req = 001, fm_addr = 0x1000, cmd_ready = 1 -> grant = 001 one cycle later, cmd_valid one cycle with cmd_addr = 0x1000, cmd_len = 10240, cmd_write = 0; xfer_done after 5 cycles -> done = 001 for one cycle, then IDLE.
REQ-021 Round-robin: req = 111 held, each transfer completed -> grant order 001, 010, 100, 001; SAVE command has cmd_write = 1.
REQ-022 Backpressure: cmd_ready = 0 for 7 cycles in ISSUE -> cmd_valid and cmd_addr stay stable for 8 cycles; BUSY is entered only on the handshake edge.
REQ-023 Spurious xfer_done in IDLE -> err = 1 and stays 1; the FSM stays in IDLE, then operates normally.
REQ-024 rst pulsed during BUSY with grant = 010 -> the next cycle shows grant = 0, done = 0, busy = 0; with req = 011 afterward, the first grant = 001.
REQ-025 wt_addr changed from 0x2000 to 0x3000 during ISSUE -> cmd_addr stays 0x2000.

Source files
------------

// File: rtl/ddr_port_arbiter.sv
// ddr_port_arbiter: round-robin owner selection for one shared DDR command port.
// Three requesters (FM load, WT load, SAVE) each get one fixed-length command
// per grant. The FSM walks IDLE -> ISSUE -> BUSY -> DONE -> IDLE.
module ddr_port_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 23,
  parameter logic [LEN_WIDTH-1:0] FM_LEN   = LEN_WIDTH'(10240),
  parameter logic [LEN_WIDTH-1:0] WT_LEN   = LEN_WIDTH'(10240),
  parameter logic [LEN_WIDTH-1:0] SAVE_LEN = LEN_WIDTH'(10240)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [2:0]            req,
  input  logic [ADDR_WIDTH-1:0] fm_addr,
  input  logic [ADDR_WIDTH-1:0] wt_addr,
  input  logic [ADDR_WIDTH-1:0] save_addr,
  output logic [2:0]            grant,
  output logic [2:0]            done,
  output logic                  cmd_valid,
  input  logic                  cmd_ready,
  output logic [ADDR_WIDTH-1:0] cmd_addr,
  output logic [LEN_WIDTH-1:0]  cmd_len,
  output logic                  cmd_write,
  input  logic                  xfer_done,
  output logic                  busy,
  output logic                  err
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_BUSY, S_DONE} state_t;

  state_t state, next_state;

  logic [1:0]            last_grant;  // index of the most recently completed owner
  logic [1:0]            cur_idx;     // index of the current owner
  logic [2:0]            sel;
  logic [1:0]            sel_idx;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [LEN_WIDTH-1:0]  sel_len;
  logic                  grant_load;
  logic                  issue_ack;
  logic                  finish;

  // Round-robin pick: scan starting one past the last owner, wrapping at 3.
  always_comb begin
    sel     = '0;
    sel_idx = '0;
    for (int k = 0; k < 3; k++) begin
      int i;
      i = int'(last_grant) + 1 + k;
      if (i >= 3) i = i - 3;
      if (sel == '0 && req[i]) begin
        sel[i]  = 1'b1;
        sel_idx = 2'(i);
      end
    end
  end

  // Address and length of the selected requester.
  always_comb begin
    sel_addr = fm_addr;
    sel_len  = FM_LEN;
    case (sel_idx)
      2'd1:    begin sel_addr = wt_addr;   sel_len = WT_LEN;   end
      2'd2:    begin sel_addr = save_addr; sel_len = SAVE_LEN; end
      default: begin sel_addr = fm_addr;   sel_len = FM_LEN;   end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  // Next-state logic; DONE always returns to IDLE without arbitrating.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (req != 3'b000) next_state = S_ISSUE;
      S_ISSUE: if (cmd_ready)     next_state = S_BUSY;
      S_BUSY:  if (xfer_done)     next_state = S_DONE;
      S_DONE:                     next_state = S_IDLE;
      default:                    next_state = S_IDLE;
    endcase
  end

  // Transition strobes that drive the registered outputs.
  always_comb begin
    grant_load = (state == S_IDLE)  && (req != 3'b000);
    issue_ack  = (state == S_ISSUE) && cmd_ready;
    finish     = (state == S_BUSY)  && xfer_done;
  end

  // Registered outputs: command captured at grant and held until the next grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant      <= '0;
      done       <= '0;
      cmd_valid  <= 1'b0;
      cmd_addr   <= '0;
      cmd_len    <= '0;
      cmd_write  <= 1'b0;
      busy       <= 1'b0;
      err        <= 1'b0;
      last_grant <= 2'd2;
      cur_idx    <= 2'd0;
    end else begin
      done <= '0;
      if (grant_load) begin
        grant     <= sel;
        cmd_valid <= 1'b1;
        cmd_addr  <= sel_addr;
        cmd_len   <= sel_len;
        cmd_write <= (sel_idx == 2'd2);
        cur_idx   <= sel_idx;
      end
      if (issue_ack) cmd_valid <= 1'b0;
      if (finish) begin
        done       <= grant;
        grant      <= '0;
        last_grant <= cur_idx;
      end
      busy <= (next_state != S_IDLE);
      // A completion pulse outside BUSY is a protocol violation; sticky until reset.
      if (xfer_done && state != S_BUSY) err <= 1'b1;
    end
  end

endmodule
